// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the serial-in/parallel-out deframer: FSM encoding
// and the default frame width.
package sipo_deframer_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Data-bit counter for the deframer: clears on a start bit, counts captured
// bits and flags the last one. It saturates rather than wrapping; the FSM
// leaves DATA on the terminal count and the next start bit clears it.
module sipo_bit_counter #(
    parameter int N  = 4,
    parameter int CW = (N > 2) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CW'(N - 1));

endmodule

// File: rtl/sipo_deframer.sv
// Start/data/stop deframer: shifts an LSB-first serial stream into an N-bit
// word and hands it to a valid/ready consumer, flagging bad stops and drops.
module sipo_deframer
    import sipo_deframer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SI,
    input  logic         en,
    input  logic         ready,
    output logic [N-1:0] Q,
    output logic         valid,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);

    state_t       state;
    logic [N-1:0] sreg;
    logic         bit_tc;

    sipo_bit_counter #(.N(N)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE && en && !SI),
        .en    (state == DATA && en),
        .tc    (bit_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            Q         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A hand-off frees Q; a completion below may refill it on the same edge.
            if (valid && ready)
                valid <= 1'b0;
            case (state)
                IDLE: if (en && !SI) state <= DATA;
                DATA: if (en) begin
                    sreg <= {SI, sreg[N-1:1]};
                    if (bit_tc)
                        state <= STOP;
                end
                STOP: if (en) begin
                    state <= IDLE;
                    if (SI) begin
                        if (!valid || ready) begin
                            Q     <= sreg;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer (N=4): one task per scenario, inline checks.
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SI = 1'b1;
    logic       en = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] Q;
    logic       valid, busy, frame_err, overrun;

    int tests = 0;
    int fails = 0;

    sipo_deframer #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .SI        (SI),
        .en        (en),
        .ready     (ready),
        .Q         (Q),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic s, input logic e, input logic r);
        SI = s; en = e; ready = r;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic r_data,
                              input logic r_stop, input logic gaps);
        step(1'b0, 1'b1, r_data);
        if (gaps) step(1'b1, 1'b0, r_data);
        for (int i = 0; i < 4; i++) begin
            step(d[i], 1'b1, r_data);
            if (gaps) step(~d[i], 1'b0, r_data);
        end
        step(1'b1, 1'b1, r_stop);
    endtask

    task automatic pulse_reset();
        reset = 1'b1; #2;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        tests++; if (Q !== 4'h0) begin fails++; $display("FAIL reset_Q got=%h exp=0", Q); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_on_mark got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        // Stream 0,1,0,1,1,1: start, data 1,0,1,1 LSB first, stop.
        step(1'b0, 1'b1, 1'b1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_valid_before_stop got=%b exp=0", valid); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b1 || Q !== 4'hD) begin fails++; $display("FAIL basic_word got=%b/%h exp=1/d", valid, Q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after_stop got=%b exp=0", busy); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_valid_clear got=%b exp=0", valid); end
    endtask

    task automatic test_overrun();
        send_frame(4'hD, 1'b0, 1'b0, 1'b0);
        tests++; if (valid !== 1'b1 || Q !== 4'hD || overrun !== 1'b0) begin
            fails++; $display("FAIL ovr_first got=%b/%h/%b exp=1/d/0", valid, Q, overrun); end
        send_frame(4'h3, 1'b0, 1'b0, 1'b0);
        tests++; if (valid !== 1'b1 || Q !== 4'hD || overrun !== 1'b1) begin
            fails++; $display("FAIL ovr_drop got=%b/%h/%b exp=1/d/1", valid, Q, overrun); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0 || overrun !== 1'b1) begin
            fails++; $display("FAIL ovr_sticky got=%b/%b exp=0/1", valid, overrun); end
        pulse_reset();
        tests++; if (overrun !== 1'b0 || Q !== 4'h0) begin
            fails++; $display("FAIL ovr_reset_clear got=%b/%h exp=0/0", overrun, Q); end
    endtask

    task automatic test_frame_err();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
        tests++; if (valid !== 1'b0 || Q !== 4'h0) begin fails++; $display("FAIL ferr_discard got=%b/%h exp=0/0", valid, Q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_idle got=%b exp=0", busy); end
        step(1'b1, 1'b1, 1'b0);
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
    endtask

    task automatic test_en_gaps();
        step(1'b0, 1'b0, 1'b1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_idle_hold got=%b exp=0", busy); end
        send_frame(4'hA, 1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b1 || Q !== 4'hA) begin fails++; $display("FAIL gap_word got=%b/%h exp=1/a", valid, Q); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL gap_valid_clear got=%b exp=0", valid); end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b1; #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL rst_hold got=%b/%b/%b exp=0/0/0", busy, valid, frame_err); end
        reset = 1'b0;
        // Leftover bits of the abandoned frame must not be seen as a frame.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_abandon got=%b/%b exp=0/0", valid, busy); end
        send_frame(4'h5, 1'b1, 1'b1, 1'b0);
        tests++; if (valid !== 1'b1 || Q !== 4'h5) begin fails++; $display("FAIL rst_fresh got=%b/%h exp=1/5", valid, Q); end
        step(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_frame(4'h9, 1'b0, 1'b0, 1'b0);
        tests++; if (valid !== 1'b1 || Q !== 4'h9) begin fails++; $display("FAIL b2b_first got=%b/%h exp=1/9", valid, Q); end
        send_frame(4'h6, 1'b0, 1'b1, 1'b0);
        tests++; if (valid !== 1'b1 || Q !== 4'h6) begin fails++; $display("FAIL b2b_replace got=%b/%h exp=1/6", valid, Q); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_no_overrun got=%b exp=0", overrun); end
        step(1'b1, 1'b1, 1'b1);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_en_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 SHALL have parameter N, default 4, meaning data bits per frame (N >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SI  input  1  serial bit stream from the upstream shift register's SO, LSB first.
REQ-005 SHALL have port en  input  1  bit strobe; SI is sampled only on edges where en=1.
REQ-006 SHALL have port ready  input  1  consumer accepts Q on an edge where valid=1 and ready=1.
REQ-007 SHALL have port Q  output  N  received data word, stable while valid=1.
REQ-008 SHALL have port valid  output  1  Q holds an unconsumed word.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky; a completed word was dropped because valid=1 and ready=0.

Function
REQ-012 SHALL implement an FSM with states IDLE, DATA and STOP, all registered.
REQ-013 In IDLE, en=1 with SI=0 (start bit) SHALL transition to DATA and clear the bit counter; en=1 with SI=1 SHALL stay in IDLE.
REQ-014 In DATA, each en=1 edge SHALL shift SI into the MSB of an N-bit shift register (right shift), so the first data bit ends in bit 0.
REQ-015 In DATA, the bit counter SHALL increment per en=1 edge, and the FSM SHALL move to STOP on the edge capturing bit N-1.
REQ-016 In STOP, en=1 with SI=1 SHALL complete the frame and return to IDLE.
REQ-017 In STOP, en=1 with SI=0 SHALL pulse frame_err for exactly one cycle, discard the word, leave Q/valid unchanged and return to IDLE.
REQ-018 In any state, edges with en=0 SHALL hold the FSM, counter and shift register unchanged.
REQ-019 On frame completion with valid=0, or with valid=1 and ready=1 on the same edge, Q SHALL load the shift register and valid SHALL be 1 from the next cycle (latency 1 edge after the stop bit).
REQ-020 On frame completion with valid=1 and ready=0, Q SHALL keep the old word and overrun SHALL set until reset.
REQ-021 With valid=1 and ready=1 and no completion on that edge, valid SHALL clear on that edge.
REQ-022 ready SHALL be ignored while valid=0.
REQ-023 busy SHALL be combinational from state (state != IDLE); all other outputs SHALL be registered.
REQ-024 The bit counter SHALL be sized to count 0..N-1; counting wraps only through the STOP transition, never arithmetically.

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, counter=0, shift register=0, Q=0, valid=0, frame_err=0 and overrun=0, regardless of clk.
REQ-026 Reset asserted mid-frame SHALL abandon the partial word with no valid or frame_err pulse, and the next start bit after release SHALL begin a fresh frame.

Structure
REQ-027 State encoding (IDLE/DATA/STOP) and the default width constant SHALL live in the shared package sipo_deframer_pkg.
REQ-028 The bit counter SHALL be the sub-module sipo_bit_counter (enable, clear, terminal-count output); everything else SHALL stay inline.

Verification (N=4)
REQ-029 Stimulus: en=1 each cycle, SI = 0,1,0,1,1,1 with ready=1. Required: valid=1 with Q=4'hD one cycle after the stop edge; valid clears on the next edge.
REQ-030 Stimulus: frame 0xD with ready=0, then frame 0x3. Required: Q stays 0xD, valid stays 1 and overrun=1 after the second stop edge.
REQ-031 Stimulus: start, 4 data bits, then stop bit SI=0. Required: one-cycle frame_err, valid stays 0 and state returns to IDLE.
REQ-032 Stimulus: frame 0xA with en toggling 1,0,1,0 between bits. Required: Q=4'hA with the same result as continuous en.
REQ-033 Stimulus: reset pulsed after 2 data bits, then a full frame 0x5. Required: only Q=4'h5 is delivered and busy=0 during reset.
REQ-034 Stimulus: valid=1 held with ready=0 until the edge where the next stop bit lands, ready=1 on that same edge. Required: Q becomes the new word, valid stays 1 and overrun stays 0.
